// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and small helpers for the VGA frame driver.
package vga_pkg;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 4-bit-per-channel colour as held in the frame shadow
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Counter width for a modulo-n counter; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_frame_driver_if.sv
// Colour request in, VGA pins out. The register block is the master,
// the frame driver is the slave.
interface vga_frame_driver_if;

  logic [3:0] red_i;
  logic [3:0] green_i;
  logic [3:0] blue_i;
  logic       w_enable;
  logic       Hsync;
  logic       Vsync;
  logic [3:0] vgaRed;
  logic [3:0] vgaGreen;
  logic [3:0] vgaBlue;
  logic       frame_start;

  modport master (
    output red_i, green_i, blue_i, w_enable,
    input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, frame_start
  );

  modport slave (
    input  red_i, green_i, blue_i, w_enable,
    output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, frame_start
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider plus horizontal/vertical position counters.
// frame_wrap flags the tick on which both counters return to (0,0).
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int H_W     = cnt_width(H_TOTAL),
  parameter int V_W     = cnt_width(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           pix_tick,
  output logic           frame_wrap
);

  localparam int DIV_W = cnt_width(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] div;
  logic             h_last;
  logic             v_last;

  // With CLK_DIV=1 div is pinned at 0, so every clock is a tick
  assign pix_tick   = (div == DIV_LAST);
  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_wrap = pix_tick && h_last && v_last;

  // Advance divider every clock and the raster position on each pixel tick
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_frame_driver.sv
// VGA frame driver: sync/blanking decode and per-frame colour shadow on top
// of the raster counters. All pins are registered and move only on pixel ticks.
module vga_frame_driver
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input logic                clk,
  input logic                reset,
  vga_frame_driver_if.slave  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = cnt_width(H_TOTAL);
  localparam int V_W     = cnt_width(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG    = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG    = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           pix_tick;
  logic           frame_wrap;

  rgb_t shadow_rgb;
  logic shadow_en;

  logic hsync_d, vsync_d;
  rgb_t rgb_d;

  logic hsync_q, vsync_q, frame_start_q;
  rgb_t rgb_q;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_W     (H_W),
    .V_W     (V_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pix_tick   (pix_tick),
    .frame_wrap (frame_wrap)
  );

  // Decode sync pulses and visible colour for the current raster position
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    rgb_d   = '0;
    if (h_cnt >= HS_BEG && h_cnt < HS_END) hsync_d = 1'b0;
    if (v_cnt >= VS_BEG && v_cnt < VS_END) vsync_d = 1'b0;
    if (h_cnt < H_ACT_END && v_cnt < V_ACT_END && shadow_en) rgb_d = shadow_rgb;
  end

  // Capture the requested colour once per frame, on the wrap to (0,0)
  // NOTE: the shadow is reset so the first frame after reset is defined black
  // rather than showing whatever the flops powered up with.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_rgb <= '0;
      shadow_en  <= 1'b0;
    end else if (frame_wrap) begin
      shadow_rgb <= '{r: vga.red_i, g: vga.green_i, b: vga.blue_i};
      shadow_en  <= vga.w_enable;
    end
  end

  // Register pin values on each tick from the pre-increment position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else if (pix_tick) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  // One-clock frame marker following the tick that lands on (0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_start_q <= 1'b0;
    else       frame_start_q <= frame_wrap;
  end

  assign vga.Hsync       = hsync_q;
  assign vga.Vsync       = vsync_q;
  assign vga.vgaRed      = rgb_q.r;
  assign vga.vgaGreen    = rgb_q.g;
  assign vga.vgaBlue     = rgb_q.b;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_driver.sv
// Directed bench for vga_frame_driver. Horizontal timing and CLK_DIV are the
// real 640-wide values; the vertical totals are shortened (3 active, 1 FP,
// 2 sync, 1 BP = 7 lines) so several full frames fit in a short run.
// Clock index p = posedges since reset release. The pixel index P = 800*line + h
// (counted across frames) is visible from the negedge after posedge 2*(P+1).
module tb_vga_frame_driver;
  import vga_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_frame_driver_if vif();

  vga_frame_driver #(
    .CLK_DIV (2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(3),   .V_FP(1),  .V_SYNC(2),  .V_BP(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif)
  );

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int   total = 0;
  int   bad   = 0;
  int   fs_count = 0;
  logic count_fs = 1'b0;

  always @(negedge clk) begin
    if (count_fs && vif.frame_start) fs_count <= fs_count + 1;
  end

  typedef struct {
    int         p;
    bit         apply;
    logic [3:0] ri, gi, bi;
    logic       en;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] pack(input logic hs, input logic vs,
                                       input logic [3:0] r, input logic [3:0] g,
                                       input logic [3:0] b, input logic fs);
    return {hs, vs, r, g, b, fs};
  endfunction

  function automatic logic [14:0] pins();
    return {vif.Hsync, vif.Vsync, vif.vgaRed, vif.vgaGreen, vif.vgaBlue, vif.frame_start};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int p, input logic hs, input logic vs,
                     input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                     input logic fs);
    vec_t v;
    v.p = p; v.apply = 1'b0; v.ri = '0; v.gi = '0; v.bi = '0; v.en = 1'b0;
    v.exp = pack(hs, vs, r, g, b, fs);
    vecs.push_back(v);
  endtask

  // Attach an input change to the most recent vector (applied after its check)
  task automatic then_set(input logic [3:0] r, input logic [3:0] g,
                          input logic [3:0] b, input logic en);
    int k;
    k = vecs.size() - 1;
    vecs[k].apply = 1'b1;
    vecs[k].ri = r; vecs[k].gi = g; vecs[k].bi = b; vecs[k].en = en;
  endtask

  // Advance to the negedge that follows posedge p; call from a negedge
  task automatic goto(input int p);
    if (cyc > p) begin
      check($sformatf("schedule p=%0d", p), cyc, p);
      return;
    end
    while (cyc != p) @(negedge clk);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      goto(vecs[i].p);
      check($sformatf("pins p=%0d", vecs[i].p), 32'(pins()), 32'(vecs[i].exp));
      if (vecs[i].apply) begin
        vif.red_i    = vecs[i].ri;
        vif.green_i  = vecs[i].gi;
        vif.blue_i   = vecs[i].bi;
        vif.w_enable = vecs[i].en;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.red_i = 4'h3; vif.green_i = 4'h5; vif.blue_i = 4'h7; vif.w_enable = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset pins", 32'(pins()), 32'(pack(1, 1, 0, 0, 0, 0)));

    reset    = 1'b0;
    count_fs = 1'b1;
    check("release h_cnt", 32'(dut.u_counter.h_cnt), 0);
    check("release v_cnt", 32'(dut.u_counter.v_cnt), 0);

    // Frame 0: shadow still cleared, black; sync edges and first wrap
    add(2,     1, 1, 0, 0, 0, 0);
    add(1312,  1, 1, 0, 0, 0, 0);
    add(1314,  0, 1, 0, 0, 0, 0);
    add(1504,  0, 1, 0, 0, 0, 0);
    add(1506,  1, 1, 0, 0, 0, 0);
    add(2912,  1, 1, 0, 0, 0, 0);
    add(2914,  0, 1, 0, 0, 0, 0);
    add(6400,  1, 1, 0, 0, 0, 0);
    add(6402,  1, 0, 0, 0, 0, 0);
    add(9600,  1, 0, 0, 0, 0, 0);
    add(9602,  1, 1, 0, 0, 0, 0);
    add(11199, 1, 1, 0, 0, 0, 0);
    add(11200, 1, 1, 0, 0, 0, 1);
    add(11201, 1, 1, 0, 0, 0, 0);
    // Frame 1: 3/5/7 captured; red_i=A mid-frame must not show yet
    add(11202, 1, 1, 4'h3, 4'h5, 4'h7, 0);
    add(12480, 1, 1, 4'h3, 4'h5, 4'h7, 0);
    add(12482, 1, 1, 0, 0, 0, 0);
    add(13002, 1, 1, 4'h3, 4'h5, 4'h7, 0); then_set(4'hA, 4'h5, 4'h7, 1'b1);
    add(13004, 1, 1, 4'h3, 4'h5, 4'h7, 0);
    add(15002, 1, 1, 4'h3, 4'h5, 4'h7, 0);
    add(16002, 1, 1, 0, 0, 0, 0);
    add(17600, 1, 1, 0, 0, 0, 0);
    add(17602, 1, 0, 0, 0, 0, 0);
    add(22400, 1, 1, 0, 0, 0, 1);
    // Frame 2: A shows; request F/F/F with enable off mid-frame
    add(22402, 1, 1, 4'hA, 4'h5, 4'h7, 0);
    add(24022, 1, 1, 4'hA, 4'h5, 4'h7, 0); then_set(4'hF, 4'hF, 4'hF, 1'b0);
    add(24024, 1, 1, 4'hA, 4'h5, 4'h7, 0);
    add(26880, 1, 1, 4'hA, 4'h5, 4'h7, 0);
    // Frame 3: disabled -> black, syncs still run; re-enable mid-frame
    add(33602, 1, 1, 0, 0, 0, 0);
    add(34914, 0, 1, 0, 0, 0, 0);
    add(35602, 1, 1, 0, 0, 0, 0); then_set(4'hF, 4'hF, 4'hF, 1'b1);
    add(40002, 1, 0, 0, 0, 0, 0);
    // Frame 4: F in active area, blanked at h=640 and on v>=V_ACTIVE
    add(44802, 1, 1, 4'hF, 4'hF, 4'hF, 0);
    add(46080, 1, 1, 4'hF, 4'hF, 4'hF, 0);
    add(46082, 1, 1, 0, 0, 0, 0);
    add(46402, 1, 1, 4'hF, 4'hF, 4'hF, 0);
    add(49802, 1, 1, 0, 0, 0, 0);
    // Frame 5: lit pixel right before the asynchronous reset
    add(57702, 1, 1, 4'hF, 4'hF, 4'hF, 0);
    run_vecs();

    count_fs = 1'b0;
    check("frame_start pulses", fs_count, 5);

    // Reset between clock edges while colour is lit
    #2 reset = 1'b1;
    #1;
    check("async reset pins", 32'(pins()), 32'(pack(1, 1, 0, 0, 0, 0)));
    check("async reset h_cnt", 32'(dut.u_counter.h_cnt), 0);
    check("async reset v_cnt", 32'(dut.u_counter.v_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("restart h_cnt", 32'(dut.u_counter.h_cnt), 0);

    // After restart: black first frame despite F/enable requested, fresh timing
    vecs.delete();
    add(2,    1, 1, 0, 0, 0, 0);
    add(1312, 1, 1, 0, 0, 0, 0);
    add(1314, 0, 1, 0, 0, 0, 0);
    add(2802, 1, 1, 0, 0, 0, 0);
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
